branch_resolve: RTL

//  Resolves branches, jumps and halt in the ID stage of the 16-bit pipelined CPU; consumes

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/branch_cmp.sv | 32 +++
 rtl/branch_resolve.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the 16-bit pipelined CPU: branch types, key opcodes,
// and the branch-resolve FSM state.
package cpu_pkg;

  typedef enum logic [1:0] {
    BT_NONE = 2'b00,
    BT_EQ   = 2'b01,
    BT_LT   = 2'b10,
    BT_GT   = 2'b11
  } btype_e;

  localparam logic [3:0] OP_J    = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_REDIRECT = 2'b01,
    ST_HALT     = 2'b10
  } br_state_e;

endpackage

// File: rtl/branch_cmp.sv
// Signed operand compare for conditional branches.
// Produces taken for the selected branch type; none is never taken.
module branch_cmp
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [1:0]        bType,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              taken
);

  logic w_eq;
  logic w_lt;
  logic w_gt;

  assign w_eq = (op_a == op_b);
  assign w_lt = ($signed(op_a) < $signed(op_b));
  assign w_gt = ($signed(op_a) > $signed(op_b));

  always_comb begin
    taken = 1'b0;
    unique case (bType)
      BT_EQ:   taken = w_eq;
      BT_LT:   taken = w_lt;
      BT_GT:   taken = w_gt;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// ID-stage branch/jump/halt resolution with one-cycle redirect pulse.
// Optional stats counters built when BRANCH_STATS_EN is defined.
module branch_resolve
  import cpu_pkg::*;
#(
  parameter int PC_W   = 16,
  parameter int DATA_W = 16,
  parameter int BOFF_W = 8,
  parameter int JOFF_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_id,
  input  logic              stall,
  input  logic [3:0]        opcode,
  input  logic [1:0]        bType,
  input  logic              j,
  input  logic [PC_W-1:0]   pc_id,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [BOFF_W-1:0] br_off,
  input  logic [JOFF_W-1:0] jmp_off,
  output logic              jorb,
  output logic [PC_W-1:0]   target_pc,
  output logic              squash_id,
  output logic              halted,
  output logic [15:0]       br_taken_cnt,
  output logic [15:0]       br_total_cnt
);

  br_state_e       r_state;
  logic            r_jorb;
  logic            r_squash;
  logic            r_halted;
  logic [PC_W-1:0] r_target;

  logic            w_cmp_taken;
  logic            w_eval;
  logic            w_halt;
  logic            w_taken;
  logic [PC_W-1:0] w_off;
  logic [PC_W-1:0] w_target;

  branch_cmp #(.DATA_W(DATA_W)) u_cmp (
    .bType (bType),
    .op_a  (op_a),
    .op_b  (op_b),
    .taken (w_cmp_taken)
  );

  assign w_eval  = (r_state == ST_RUN) && valid_id && !stall;
  assign w_halt  = (opcode == OP_HALT);
  assign w_taken = j || w_cmp_taken;

  // Offsets are in words; shift converts to a byte-addressed PC delta.
  assign w_off = j
    ? {{(PC_W-JOFF_W){jmp_off[JOFF_W-1]}}, jmp_off}
    : {{(PC_W-BOFF_W){br_off[BOFF_W-1]}}, br_off};
  assign w_target = pc_id + (w_off << 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_RUN;
      r_jorb   <= 1'b0;
      r_squash <= 1'b0;
      r_halted <= 1'b0;
      r_target <= '0;
    end else begin
      r_jorb   <= 1'b0;
      r_squash <= 1'b0;
      unique case (r_state)
        ST_RUN: begin
          if (w_eval && w_halt) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else if (w_eval && w_taken) begin
            r_state  <= ST_REDIRECT;
            r_jorb   <= 1'b1;
            r_squash <= 1'b1;
            r_target <= w_target;
          end
        end
        ST_REDIRECT: r_state <= ST_RUN;
        ST_HALT:     r_state <= ST_HALT;
        default:     r_state <= ST_RUN;
      endcase
    end
  end

  assign jorb      = r_jorb;
  assign squash_id = r_squash;
  assign halted    = r_halted;
  assign target_pc = r_target;

`ifdef BRANCH_STATS_EN
  logic [15:0] r_taken_cnt;
  logic [15:0] r_total_cnt;
  logic        w_count;

  assign w_count = w_eval && !w_halt && (j || (bType != BT_NONE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_taken_cnt <= '0;
      r_total_cnt <= '0;
    end else if (w_count) begin
      if (r_total_cnt != 16'hFFFF)
        r_total_cnt <= r_total_cnt + 16'd1;
      if (w_taken && (r_taken_cnt != 16'hFFFF))
        r_taken_cnt <= r_taken_cnt + 16'd1;
    end
  end

  assign br_taken_cnt = r_taken_cnt;
  assign br_total_cnt = r_total_cnt;
`else
  assign br_taken_cnt = '0;
  assign br_total_cnt = '0;
`endif

endmodule
